// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the register file write port between ALU and LSU
// and tracks destination registers with writes still in flight.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nxt;
  logic              starved;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              wr_fire;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  assign starved = (starve_cnt == SMAX);

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (flush) begin
      alu_gnt = 1'b0;
    end else if (lsu_valid && alu_valid && starved) begin
      alu_gnt = 1'b1;
    end else if (lsu_valid) begin
      lsu_gnt = 1'b1;
    end else if (alu_valid) begin
      alu_gnt = 1'b1;
    end
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_comb begin
    starve_nxt = starve_cnt;
    if (flush || !alu_valid || alu_gnt) begin
      starve_nxt = '0;
    end else if (lsu_gnt && !starved) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  assign wr_rd   = alu_gnt ? alu_rd : lsu_rd;
  assign wr_data = alu_gnt ? alu_data : lsu_data;
  // rd==0 transfers are consumed but never reach the write port
  assign wr_fire = (alu_gnt || lsu_gnt) && (wr_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      we3        <= wr_fire;
      if (wr_fire) begin
        a3  <= wr_rd;
        wd3 <= wr_data;
      end
    end
  end

  // Set is applied after clear so a new producer keeps the register busy
  always_comb begin
    busy_nxt = busy;
    if (we3) begin
      busy_nxt[a3] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic,
// with writeback results checked by a separate monitor against a queue.
module tb_rf_wb_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  rf_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          starve = 0;
  bit          mbusy[32];
  int          wb_rd = 0;
  logic [4:0]  last_a3 = '0;
  logic [31:0] last_wd3 = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every write-port cycle is matched against the scoreboard
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (we3) begin
        if (q.size() == 0) begin
          chk("wb_unexpected_we3", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wb_a3", a3, e.rd);
          chk("wb_wd3", wd3, e.data);
          last_a3  = e.rd;
          last_wd3 = e.data;
        end
      end else begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wb_missing_we3", 0, 1);
        end
        chk("hold_a3", a3, last_a3);
        chk("hold_wd3", wd3, last_wd3);
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
  // g: 0 none, 1 ALU, 2 LSU (actual grant seen on the ready lines)
  task automatic step(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic iv, input logic [4:0] ir, input logic fl,
    input logic [4:0] r1, input logic [4:0] r2,
    output int g, output logic b1, output logic b2);
    int eg;
    wb_t e;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    iss_valid = iv; iss_rd = ir; flush = fl;
    rs1 = r1; rs2 = r2;
    if (fl) eg = 0;
    else if (lv && av && starve == SMAX) eg = 1;
    else if (lv) eg = 2;
    else if (av) eg = 1;
    else eg = 0;
    @(negedge clk);
    g  = alu_ready ? 1 : (lsu_ready ? 2 : 0);
    b1 = rs1_busy;
    b2 = rs2_busy;
    chk("ready", {alu_ready, lsu_ready}, {eg == 1, eg == 2});
    chk("rs1_busy", rs1_busy, (r1 != 0) && mbusy[r1]);
    chk("rs2_busy", rs2_busy, (r2 != 0) && mbusy[r2]);
    @(posedge clk);
    e.rd   = (eg == 1) ? ar : lr;
    e.data = (eg == 1) ? ad : ld;
    if (eg != 0 && e.rd != 0) q.push_back(e);
    if (fl || !av || eg == 1) starve = 0;
    else if (eg == 2 && starve < SMAX) starve++;
    if (fl) begin
      foreach (mbusy[i]) mbusy[i] = 0;
    end else begin
      if (wb_rd != 0) mbusy[wb_rd] = 0;
      if (iv && ir != 0) mbusy[ir] = 1;
    end
    wb_rd = (eg != 0) ? int'(e.rd) : 0;
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2,
                      output logic b1, output logic b2);
    int g;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, g, b1, b2);
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    wb_rd = 0;
    foreach (mbusy[i]) mbusy[i] = 0;
    last_a3 = '0;
    last_wd3 = '0;
  endtask

  initial begin
    int g;
    logic b1, b2;
    int exp_seq[8];
    exp_seq = '{2, 2, 2, 1, 2, 2, 2, 1};

    // power-on reset
    #1 rst = 1'b0;
    #2;
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // single ALU write, latency 1
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, g, b1, b2);
    chk("t1_grant", g, 1);
    idle(0, 0, b1, b2);
    idle(0, 0, b1, b2);

    // contention: starvation bound forces every fourth grant to the ALU
    for (int i = 0; i < 8; i++) begin
      step(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(20 + i), 32'hB000_0000 + i,
           0, 0, 0, 0, 0, g, b1, b2);
      chk($sformatf("t2_grant%0d", i), g, exp_seq[i]);
    end
    idle(0, 0, b1, b2);

    // LSU write to x0 is consumed with no write
    step(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, g, b1, b2);
    chk("t3_grant", g, 2);
    idle(0, 0, b1, b2);

    // scoreboard set / clear timing
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, g, b1, b2);
    chk("t4_busy_N", b1, 0);
    idle(7, 0, b1, b2);
    chk("t4_busy_N1", b1, 1);
    step(1, 7, 32'h7777, 0, 0, 0, 0, 0, 0, 7, 0, g, b1, b2);
    chk("t4_busy_M", b1, 1);
    idle(7, 0, b1, b2);
    chk("t4_busy_M1", b1, 1);
    idle(7, 0, b1, b2);
    chk("t4_busy_M2", b1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, g, b1, b2);
    step(1, 7, 32'h7778, 0, 0, 0, 0, 0, 0, 7, 0, g, b1, b2);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, g, b1, b2);
    idle(7, 0, b1, b2);
    chk("t4_reissue_busy", b1, 1);

    // flush clears the scoreboard, blocks grants, lets the pending write finish
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, g, b1, b2);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, g, b1, b2);
    step(1, 14, 32'hC0FFEE, 0, 0, 0, 1, 20, 0, 0, 0, g, b1, b2);
    step(1, 15, 32'hBAD, 0, 0, 0, 1, 11, 1, 3, 9, g, b1, b2);
    chk("t5_flush_grant", g, 0);
    chk("t5_pre_busy3", b1, 1);
    idle(3, 9, b1, b2);
    chk("t5_busy3", b1, 0);
    chk("t5_busy9", b2, 0);
    idle(20, 11, b1, b2);
    chk("t5_busy20", b1, 0);
    chk("t5_busy11", b2, 0);

    // asynchronous reset in the middle of a write cycle
    step(1, 1, 1, 1, 2, 2, 1, 12, 0, 0, 0, g, b1, b2);
    step(1, 3, 3, 1, 4, 4, 1, 25, 0, 0, 0, g, b1, b2);
    step(1, 5, 5, 1, 6, 32'h66, 0, 0, 0, 12, 25, g, b1, b2);
    chk("t6_pre_busy", {b1, b2}, 2'b11);
    chk("t6_pre_we3", we3, 1);
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk("t6_we3", we3, 0);
    chk("t6_a3", a3, 0);
    chk("t6_wd3", wd3, 0);
    chk("t6_busy", {rs1_busy, rs2_busy}, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 5'(8 + i), 32'hE0 + i, 1, 5'(16 + i), 32'hF0 + i,
           0, 0, 0, 12, 25, g, b1, b2);
      chk($sformatf("t6_grant%0d", i), g, exp_seq[i]);
    end
    idle(0, 0, b1, b2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), g, b1, b2);
    end
    idle(0, 0, b1, b2);
    idle(0, 0, b1, b2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
